// File: rtl/neuron_td_bank_if.sv
// Event-in / record-out bundle for neuron_td_bank.
// The slave side is the neuron bank, the master side is the event source and record consumer.
interface neuron_td_bank_if #(
  parameter int unsigned NCH = 4
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          ev_valid;
  logic          ev_ready;
  logic          ev_tick;
  logic [CW-1:0] ev_chan;
  logic [1:0]    ev_weight;
  logic          stream_act;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] out_chan;

  modport master (
    output ev_valid, ev_tick, ev_chan, ev_weight, stream_act, out_ready,
    input  ev_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  ev_valid, ev_tick, ev_chan, ev_weight, stream_act, out_ready,
    output ev_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/neuron_td_bank.sv
// Bank of tick-difference neurons: weight events accumulate per channel, a tick scans all
// channels and pushes SPIKE/ACT records into a first-word-fall-through FIFO.
// Optional refractory counters are enabled by defining NEURON_TD_REFRACT_EN.
module neuron_td_bank #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned THR        = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REFRACT    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  neuron_td_bank_if.slave bus,
  output logic            busy,
  output logic            post_spike
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OW = PW + 1;
  localparam logic [2:0]  NEURON_TYPE_SPIKE = 3'd1;
  localparam logic [2:0]  NEURON_TYPE_ACT   = 3'd2;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] curr      [NCH];
  logic [WIDTH-1:0] prev      [NCH];
  logic [WIDTH-1:0] last_diff [NCH];

  logic [7:0]       data_mem  [FIFO_DEPTH];
  logic [CW-1:0]    chan_mem  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    count;

  logic [WIDTH-1:0] cur_sel, prv_sel, diff, sat;
  logic [WIDTH:0]   sum;
  logic [3:0]       nib;
  logic [7:0]       rec;
  logic             fire, push, full, stall, proc_ch, push_do, pop;
  logic             accept_w, accept_t, out_valid;

`ifdef NEURON_TD_REFRACT_EN
  localparam int unsigned RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  logic [RW-1:0] refr [NCH];
`endif

  // Scan datapath, FIFO status and handshake decode.
  always_comb begin
    cur_sel = curr[idx];
    prv_sel = prev[idx];
    diff    = (cur_sel >= prv_sel) ? (cur_sel - prv_sel) : '0;
    fire    = (32'(diff) >= 32'(THR));
`ifdef NEURON_TD_REFRACT_EN
    if (refr[idx] != '0) fire = 1'b0;
`endif
    nib      = (32'(diff) > 32'd15) ? 4'hF : diff[3:0];
    rec      = {1'b1, (fire ? NEURON_TYPE_SPIKE : NEURON_TYPE_ACT), nib};
    full     = (count == OW'(FIFO_DEPTH));
    push     = (state == S_SCAN) && (fire || bus.stream_act);
    stall    = push && full;
    proc_ch  = (state == S_SCAN) && !stall;
    push_do  = push && !full;
    out_valid = (count != '0);
    pop      = out_valid && bus.out_ready;
    accept_w = (state == S_IDLE) && bus.ev_valid && !bus.ev_tick;
    accept_t = (state == S_IDLE) && bus.ev_valid && bus.ev_tick;
    sum      = {1'b0, curr[bus.ev_chan]} + (WIDTH + 1)'(bus.ev_weight);
    sat      = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: begin
        if (accept_t) begin
          state_n = S_SCAN;
          idx_n   = '0;
        end
      end
      S_SCAN: begin
        if (proc_ch) begin
          if (idx == CW'(NCH - 1)) begin
            state_n = S_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + CW'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Per-channel accumulators; weight events only land in IDLE, scans only touch SCAN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) begin
        curr[i]      <= '0;
        prev[i]      <= '0;
        last_diff[i] <= '0;
      end
    end else if (accept_w) begin
      curr[bus.ev_chan] <= sat;
    end else if (proc_ch) begin
      prev[idx]      <= cur_sel;
      last_diff[idx] <= diff;
      curr[idx]      <= '0;
    end
  end

`ifdef NEURON_TD_REFRACT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) refr[i] <= '0;
    end else if (proc_ch) begin
      if (fire)                 refr[idx] <= RW'(REFRACT);
      else if (refr[idx] != '0) refr[idx] <= refr[idx] - RW'(1);
    end
  end
`endif

  // FIFO storage needs no reset: occupancy gates everything visible.
  always_ff @(posedge clk) begin
    if (push_do) begin
      data_mem[wr_ptr] <= rec;
      chan_mem[wr_ptr] <= idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_spike <= 1'b0;
    end else begin
      if (push_do) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count      <= count + OW'(push_do) - OW'(pop);
      post_spike <= push_do && fire;
    end
  end

  assign bus.ev_ready  = (state == S_IDLE);
  assign busy          = (state == S_SCAN);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign bus.out_chan  = out_valid ? chan_mem[rd_ptr] : '0;

endmodule
